fp64_add_scheduler: RTL and testbench

//  Shares one multi-cycle FP64 adder core among NUM_REQ requesters (e.g. several Avalon-MM operand wrappers).

---
 rtl/fp64_add_scheduler_pkg.sv | 18 +
 rtl/fp64_add_scheduler_arbiter.sv | 30 +++
 rtl/fp64_add_scheduler.sv | 111 +++++++++++
 tb/tb_fp64_add_scheduler.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_add_scheduler_pkg.sv
// Shared constants and FSM encoding for the FP64 adder scheduler.
package fp64_add_scheduler_pkg;

  localparam int FP64_W = 64;
  localparam logic [FP64_W-1:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fp64_add_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp64_add_scheduler.sv
// Shares one multi-cycle FP64 adder among NUM_REQ requesters, one operation in flight,
// with a watchdog that substitutes qNaN and flags a sticky error when the core hangs.
module fp64_add_scheduler
  import fp64_add_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP64_W-1:0] req_a,
  input  logic [NUM_REQ*FP64_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [FP64_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      core_start,
  output logic [FP64_W-1:0]         core_a,
  output logic [FP64_W-1:0]         core_b,
  input  logic                      core_done,
  input  logic [FP64_W-1:0]         core_result,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clear
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0]   wd_cnt;
  logic               handshake;
  logic               wd_fire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // Grants are suppressed while reset is held so every output reads 0.
  assign req_ready = (state == ST_IDLE && reset) ? gnt : '0;
  assign handshake = (state == ST_IDLE) && (|gnt);
  assign wd_fire   = (state == ST_WAIT) && !core_done && (wd_cnt == CNT_LAST);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      wd_cnt      <= '0;
      core_start  <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // A watchdog abort outranks a simultaneous clear request.
      if (wd_fire)        timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (handshake) begin
            core_a     <= req_a[int'(gnt_idx)*FP64_W +: FP64_W];
            core_b     <= req_b[int'(gnt_idx)*FP64_W +: FP64_W];
            owner      <= gnt_idx;
            ptr        <= IDX_W'(next_idx(int'(gnt_idx), NUM_REQ));
            core_start <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          core_start <= 1'b0;
          wd_cnt     <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            rsp_data  <= core_result;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= ST_RESP;
          end else if (wd_cnt == CNT_LAST) begin
            rsp_data  <= FP64_QNAN;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_add_scheduler.sv
// Bench for fp64_add_scheduler: behavioural latency-L adder core plus a round-robin reference model.
module tb_fp64_add_scheduler;

  localparam int N  = 4;
  localparam int TO = 15;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*64-1:0] req_a = '0;
  logic [N*64-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [63:0]     rsp_data;
  logic [N-1:0]    rsp_ready = '1;
  logic            core_start;
  logic [63:0]     core_a, core_b;
  logic            core_done = 1'b0;
  logic [63:0]     core_result = '0;
  logic            busy, timeout_err;
  logic            err_clear = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  int          core_lat = 4;
  bit          core_hang = 1'b0;
  int          cd = 0;
  logic [63:0] pend = '0;

  always #5 clk = ~clk;

  fp64_add_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .core_start  (core_start),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
    if (a == 64'h40092AF77DB8CC83 && b == 64'h4018F0329122D34E) return 64'h4022C2D727FF9CC8;
    if (a == 64'hC035A77C30B4E545 && b == 64'h40846EF84C02BC6E) return 64'h4083C1BC6A7D1544;
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rnd_fp();
    return {1'($urandom), 11'($urandom_range(1000, 1046)), 20'($urandom), 32'($urandom)};
  endfunction

  // Adder core: done pulses core_lat cycles after the cycle in which start was high.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      cd   = core_lat;
      pend = fp_add(core_a, core_b);
    end
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0 && !core_hang) begin
        core_done   <= 1'b1;
        core_result <= pend;
      end
    end
  end

  // Single request from idx starting at a negedge (cycle 0); returns the cycle rsp_valid appears.
  task automatic issue_and_wait(input int idx, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] exp, output int cyc);
    req_a[idx*64 +: 64] = a;
    req_b[idx*64 +: 64] = b;
    req_valid = N'(1) << idx;
    exp = fp_add(a, b);
    exp_ptr = (idx + 1) % N;
    cyc = -1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    for (int c = 1; c < 60; c++) begin
      if (rsp_valid != 0) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    req_valid = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 0 || rsp_valid !== 0 || core_start !== 0 || busy !== 0 ||
        timeout_err !== 0 || rsp_data !== 0 || core_a !== 0 || core_b !== 0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rsp_valid=%b start=%b busy=%b err=%b data=%h required all 0",
               req_ready, rsp_valid, core_start, busy, timeout_err, rsp_data);
    end
    req_valid = '0;
    reset = 1'b1;
    exp_ptr = 0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || req_ready !== 0 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL reset_release busy=%b ready=%b rsp_valid=%b required 0", busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_rr(input logic [N-1:0] mask, input int nops, input bit hold, output int order[$]);
    logic [N-1:0] vmask;
    logic [63:0]  ea, eb, exp_d;
    int owner, ops, cyc, w;
    bit granted, pending;
    vmask = mask; owner = -1; ops = 0; cyc = 0; pending = 0;
    ea = '0; eb = '0; exp_d = '0;
    order = {};
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = rnd_fp();
      req_b[i*64 +: 64] = rnd_fp();
    end
    if (hold) begin
      req_a[2*64 +: 64] = 64'hC035A77C30B4E545;
      req_b[2*64 +: 64] = 64'h40846EF84C02BC6E;
    end
    req_valid = vmask;
    while (ops < nops && cyc < 400) begin
      #1;
      granted = 0;
      if (req_ready != 0) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && vmask[(exp_ptr + k) % N]) w = (exp_ptr + k) % N;
        checks++;
        if (pending || w < 0 || req_ready !== (N'(1) << w)) begin
          errors++;
          $display("FAIL rr_grant got %b required winner %0d (busy op pending=%0d)", req_ready, w, pending);
        end
        if (w >= 0) begin
          owner = w;
          ea = req_a[w*64 +: 64];
          eb = req_b[w*64 +: 64];
          exp_d = fp_add(ea, eb);
          exp_ptr = (w + 1) % N;
          order.push_back(w);
          granted = 1;
          pending = 1;
          core_lat = $urandom_range(1, 6);
        end
      end
      if (core_start) begin
        checks++;
        if (core_a !== ea || core_b !== eb) begin
          errors++;
          $display("FAIL rr_core_ops got a=%h b=%h required a=%h b=%h", core_a, core_b, ea, eb);
        end
      end
      if (rsp_valid != 0) begin
        checks++;
        if (owner < 0 || rsp_valid !== (N'(1) << owner) || rsp_data !== exp_d) begin
          errors++;
          $display("FAIL rr_rsp got valid=%b data=%h required owner %0d data=%h", rsp_valid, rsp_data, owner, exp_d);
        end
        ops++;
        pending = 0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (granted) begin
        if (hold) begin
          req_a[owner*64 +: 64] = rnd_fp();
          req_b[owner*64 +: 64] = rnd_fp();
        end else begin
          vmask[owner] = 1'b0;
        end
      end
      req_valid = vmask;
    end
    req_valid = '0;
    checks++;
    if (ops != nops) begin
      errors++;
      $display("FAIL rr_budget completed %0d ops required %0d", ops, nops);
    end
  endtask

  task automatic test_two_req();
    int order[$];
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_ptr = 0;
    test_rr(4'b1010, 2, 1'b0, order);
    checks++;
    if (order.size() != 2 || order[0] != 1 || order[1] != 3) begin
      errors++;
      $display("FAIL two_req_order got %p required '{1,3}", order);
    end
  endtask

  task automatic test_all_req();
    int order[$];
    bit bad;
    test_rr(4'b1111, 8, 1'b1, order);
    bad = (order.size() != 8);
    foreach (order[k]) if (order[k] != k % 4) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL all_req_order got %p required 0,1,2,3,0,1,2,3", order);
    end
  endtask

  task automatic test_single();
    logic [63:0] exp;
    int cyc;
    cyc = -1;
    core_lat = 4;
    req_a[63:0] = 64'h40092AF77DB8CC83;
    req_b[63:0] = 64'h4018F0329122D34E;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b required 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    exp_ptr = 1;
    checks++;
    if (core_start !== 1 || busy !== 1 || core_a !== 64'h40092AF77DB8CC83 || core_b !== 64'h4018F0329122D34E) begin
      errors++;
      $display("FAIL single_start start=%b busy=%b a=%h b=%h required start 1 with vector operands",
               core_start, busy, core_a, core_b);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 0) begin
      errors++;
      $display("FAIL single_start_pulse start=%b at cycle 2 required 0", core_start);
    end
    for (int c = 2; c < 40; c++) begin
      if (rsp_valid != 0) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (cyc != 6 || rsp_valid !== 4'b0001 || rsp_data !== 64'h4022C2D727FF9CC8) begin
      errors++;
      $display("FAIL single_rsp cycle=%0d valid=%b data=%h required cycle 6 valid 0001 data 4022c2d727ff9cc8",
               cyc, rsp_valid, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 0 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL single_idle busy=%b rsp_valid=%b required 0", busy, rsp_valid);
    end
    core_lat = 1;
    issue_and_wait(3, rnd_fp(), rnd_fp(), exp, cyc);
    checks++;
    if (cyc != 3 || rsp_valid !== 4'b1000 || rsp_data !== exp) begin
      errors++;
      $display("FAIL min_latency cycle=%0d valid=%b data=%h required cycle 3 valid 1000 data %h",
               cyc, rsp_valid, rsp_data, exp);
    end
    @(negedge clk);
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL min_latency_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a0, b0, a1, b1;
    int cyc;
    bit bad;
    a0 = rnd_fp(); b0 = rnd_fp(); a1 = rnd_fp(); b1 = rnd_fp();
    core_lat = 3;
    rsp_ready = '0;
    req_a[63:0] = a0; req_b[63:0] = b0;
    req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_a[127:64] = a1; req_b[127:64] = b1;
    req_valid = 4'b0010;
    cyc = -1;
    for (int c = 1; c < 40; c++) begin
      if (rsp_valid != 0) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL bp_first_rsp cycle=%0d required 5", cyc);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 4'b0001 || rsp_data !== fp_add(a0, b0) || req_ready !== 0 || busy !== 1) bad = 1;
      rsp_ready = {2'b00, 1'(k % 2), 1'b0};
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold valid=%b data=%h ready=%b required held 0001 / %h with no grant",
               rsp_valid, rsp_data, req_ready, fp_add(a0, b0));
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_next_grant got %b required 0010", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    exp_ptr = 2;
    cyc = -1;
    for (int c = 1; c < 40; c++) begin
      if (rsp_valid != 0) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (cyc < 0 || rsp_valid !== 4'b0010 || rsp_data !== fp_add(a1, b1)) begin
      errors++;
      $display("FAIL bp_second_rsp cycle=%0d valid=%b data=%h required 0010 / %h",
               cyc, rsp_valid, rsp_data, fp_add(a1, b1));
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [63:0] exp;
    int cyc;
    core_hang = 1'b1;
    issue_and_wait(0, rnd_fp(), rnd_fp(), exp, cyc);
    checks++;
    if (cyc != 17 || rsp_valid !== 4'b0001 || rsp_data !== QNAN || timeout_err !== 1) begin
      errors++;
      $display("FAIL timeout_rsp cycle=%0d valid=%b data=%h err=%b required cycle 17 0001 qNaN err 1",
               cyc, rsp_valid, rsp_data, timeout_err);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (timeout_err !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL timeout_sticky err=%b busy=%b required err 1 busy 0", timeout_err, busy);
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 0) begin
      errors++;
      $display("FAIL timeout_clear err=%b required 0", timeout_err);
    end
    err_clear = 1'b1;
    issue_and_wait(1, rnd_fp(), rnd_fp(), exp, cyc);
    checks++;
    if (cyc != 17 || rsp_data !== QNAN || timeout_err !== 1) begin
      errors++;
      $display("FAIL timeout_set_wins cycle=%0d data=%h err=%b required cycle 17 qNaN err 1",
               cyc, rsp_data, timeout_err);
    end
    @(negedge clk);
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 0) begin
      errors++;
      $display("FAIL timeout_clear_after err=%b required 0", timeout_err);
    end
    core_hang = 1'b0;
    core_lat = TO;
    issue_and_wait(2, rnd_fp(), rnd_fp(), exp, cyc);
    checks++;
    if (cyc != 17 || rsp_valid !== 4'b0100 || rsp_data !== exp || timeout_err !== 0) begin
      errors++;
      $display("FAIL done_wins cycle=%0d valid=%b data=%h err=%b required cycle 17 0100 %h err 0",
               cyc, rsp_valid, rsp_data, timeout_err, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    int cyc;
    bit bad;
    core_lat = 10;
    req_a[63:0] = rnd_fp(); req_b[63:0] = rnd_fp();
    req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 0 || rsp_valid !== 0 || core_start !== 0 || busy !== 0 ||
        timeout_err !== 0 || rsp_data !== 0 || core_a !== 0 || core_b !== 0) begin
      errors++;
      $display("FAIL reset_mid_outputs ready=%b rsp_valid=%b start=%b busy=%b data=%h required all 0",
               req_ready, rsp_valid, core_start, busy, rsp_data);
    end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    exp_ptr = 0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy !== 0 || rsp_valid !== 0 || core_start !== 0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL late_done_ignored busy=%b rsp_valid=%b required 0 throughout", busy, rsp_valid);
    end
    core_lat = 2;
    issue_and_wait(2, rnd_fp(), rnd_fp(), exp, cyc);
    checks++;
    if (cyc != 4 || rsp_valid !== 4'b0100 || rsp_data !== exp) begin
      errors++;
      $display("FAIL post_reset_op cycle=%0d valid=%b data=%h required cycle 4 0100 %h",
               cyc, rsp_valid, rsp_data, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_two_req();
    test_all_req();
    test_single();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
